// File: rtl/msg_pkg.sv
// Shared types and constants for the ROM message sequencer.
// No logic; the state enum and the counter-width helper live here.
// Imported by rom_msg_sequencer.
package msg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;

  // Width that holds 0..n-1, but never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_msg_sequencer.sv
// Walks the message ROM from address 0 and streams each byte on a valid/ready port.
// Latency: start at edge N -> FETCH after N -> tx_valid from edge N+1; 2 cycles/byte when ready is high.
// Backpressure: tx_data/tx_valid hold in SEND until tx_ready; optional idle gap after each byte.
module rom_msg_sequencer
  import msg_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int MSG_LEN     = 11,
  parameter int GAP_CYCLES  = 0,
  parameter bit STOP_ON_NUL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int GAP_W = cnt_width(GAP_CYCLES + 1);

  // Last address of the message; the address counter stops here, it never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
  // Final count value in GAP; only meaningful when GAP_CYCLES > 0.
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DATA_W-1:0] NUL_BYTE  = DATA_W'(ASCII_NUL);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;

  // Message FSM: every output is a register updated on the edge that leaves a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel wins over everything, including a same-cycle start; no done pulse.
        state    <= IDLE;
        rom_addr <= '0;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            rom_addr <= '0;
            if (start) begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
          FETCH: begin
            tx_data <= rom_data;
            if (STOP_ON_NUL && (rom_data == NUL_BYTE)) begin
              // Terminator reached: it is latched but never presented as valid.
              state <= DONE;
            end else begin
              tx_valid <= 1'b1;
              state    <= SEND;
            end
          end
          SEND: begin
            if (tx_valid && tx_ready) begin
              tx_valid <= 1'b0;
              if (rom_addr == LAST_ADDR) begin
                state <= DONE;
              end else begin
                rom_addr <= rom_addr + 1'b1;
                if (GAP_CYCLES > 0) begin
                  gap_cnt <= '0;
                  state   <= GAP;
                end else begin
                  state <= FETCH;
                end
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= FETCH;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          DONE: begin
            // done and the busy drop appear together on the first IDLE cycle.
            done     <= 1'b1;
            busy     <= 1'b0;
            rom_addr <= '0;
            state    <= IDLE;
          end
          default: begin
            state    <= IDLE;
            rom_addr <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
